// File: rtl/fetch_buffer.sv
// Bundle FIFO between fetch and decode: DEPTH entries of {instrs, mask, pc},
// single-cycle flush on redirect, head entry driven combinationally to decode.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 2
`endif
`ifndef INSTBITS
`define INSTBITS 32
`endif
`ifndef DBITS
`define DBITS 32
`endif

module fetch_buffer #(
    parameter int FETCH_WIDTH = `FETCH_WIDTH,
    parameter int INSTBITS    = `INSTBITS,
    parameter int DBITS       = `DBITS,
    parameter int DEPTH       = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            enq_valid,
    output logic                            enq_ready,
    input  logic [INSTBITS*FETCH_WIDTH-1:0] enq_instrs,
    input  logic [FETCH_WIDTH-1:0]          enq_mask,
    input  logic [DBITS-1:0]                enq_pc,
    output logic                            deq_valid,
    input  logic                            deq_ready,
    output logic [INSTBITS*FETCH_WIDTH-1:0] deq_instrs,
    output logic [FETCH_WIDTH-1:0]          deq_mask,
    output logic [DBITS-1:0]                deq_pc,
    output logic [$clog2(DEPTH+1)-1:0]      count
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH+1);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

    logic [INSTBITS*FETCH_WIDTH-1:0] instr_q [DEPTH];
    logic [FETCH_WIDTH-1:0]          mask_q  [DEPTH];
    logic [DBITS-1:0]                pc_q    [DEPTH];

    logic [PTRW-1:0] head;
    logic [PTRW-1:0] tail;
    logic            enq_fire;
    logic            enq_write;
    logic            deq_fire;

    always_comb begin
        enq_ready = (count < FULL_CNT) && !flush;
        deq_valid = (count != '0) && !flush;
        enq_fire  = enq_valid && enq_ready;
        // An all-empty bundle completes the handshake but occupies no slot.
        enq_write = enq_fire && (enq_mask != '0);
        deq_fire  = deq_valid && deq_ready;
    end

    always_comb begin
        deq_instrs = '0;
        deq_mask   = '0;
        deq_pc     = '0;
        if (deq_valid) begin
            deq_instrs = instr_q[head];
            deq_mask   = mask_q[head];
            deq_pc     = pc_q[head];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                mask_q[i]  <= '0;
                pc_q[i]    <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq_write) begin
                instr_q[tail] <= enq_instrs;
                mask_q[tail]  <= enq_mask;
                pc_q[tail]    <= enq_pc;
                tail          <= tail + PTRW'(1);
            end
            if (deq_fire) begin
                head <= head + PTRW'(1);
            end
            if (enq_write && !deq_fire) begin
                count <= count + CNTW'(1);
            end else if (deq_fire && !enq_write) begin
                count <= count - CNTW'(1);
            end
        end
    end

endmodule
